// File: rtl/gray_sobel_pkg.sv
// Shared types and width constants for the gray/sobel streaming block.
//   mode_e  : per-frame processing mode (latched at frame start)
//   state_e : frame controller state
package gray_sobel_pkg;

   localparam int PIXEL_WIDTH_IN  = 24;
   localparam int PIXEL_WIDTH_OUT = 8;
   localparam int ZERO_PAD_WIDTH  = PIXEL_WIDTH_IN - PIXEL_WIDTH_OUT;

   typedef enum logic [1:0] {
      MODE_FULL   = 2'b00,   // gray -> sobel chain
      MODE_SOBEL  = 2'b01,   // sobel on in_pixel[7:0]
      MODE_GRAY   = 2'b10,   // gray only
      MODE_BYPASS = 2'b11    // raw pixel passthrough
   } mode_e;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      DRAIN = 2'b10
   } state_e;

endpackage

// File: rtl/gray_scale_core.sv
// RGB888 -> 8-bit luma, Y = (77*R + 150*G + 29*B) >> 8, two register stages.
//   clk_i, rst_ni        : clock, async active-low reset
//   px_rdy_i / pixel_i   : input strobe and packed RGB (R in [23:16])
//   px_rdy_o / gray_o    : output strobe and luma, two cycles after px_rdy_i
module gray_scale_core
   import gray_sobel_pkg::*;
(
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       px_rdy_i,
   input  logic [PIXEL_WIDTH_IN-1:0]  pixel_i,
   output logic                       px_rdy_o,
   output logic [PIXEL_WIDTH_OUT-1:0] gray_o
);
   localparam int STAGES = 1;

   // vld_pipe[s] marks valid data sitting in register stage s
   logic [STAGES:0] vld_pipe;
   logic [15:0]     sum_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vld_pipe <= '0;
         sum_q    <= '0;
         gray_o   <= '0;
      end else begin
         vld_pipe <= {vld_pipe[STAGES-1:0], px_rdy_i};
         if (px_rdy_i)
            sum_q <= 16'(77 * int'(pixel_i[23:16]) + 150 * int'(pixel_i[15:8]) + 29 * int'(pixel_i[7:0]));
         if (vld_pipe[0])
            gray_o <= sum_q[15:8];
      end
   end

   assign px_rdy_o = vld_pipe[STAGES];

endmodule

// File: rtl/px_out_fifo.sv
// Synchronous FIFO for processed pixels. DEPTH must be a power of two.
//   wr_en_i / wr_data_i : push; dropped (drop_o) when full and no pop this cycle
//   rd_en_i             : pop request, ignored when empty
//   rd_data_o           : head entry, zero when empty
//   empty_o, count_o    : occupancy
module px_out_fifo #(
   parameter  int WIDTH = 24,
   parameter  int DEPTH = 8,
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             wr_en_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             rd_en_i,
   output logic [WIDTH-1:0] rd_data_o,
   output logic             empty_o,
   output logic [CW-1:0]    count_o,
   output logic             drop_o
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic             full, rd_ok, wr_ok;

   assign full    = (count_o == CW'(DEPTH));
   assign empty_o = (count_o == '0);
   assign rd_ok   = rd_en_i && !empty_o;
   // a pop in the same cycle frees the slot, so a full FIFO still takes the push
   assign wr_ok   = wr_en_i && (!full || rd_ok);
   assign drop_o  = wr_en_i && full && !rd_ok;

   always_ff @(posedge clk_i) begin
      if (wr_ok)
         mem[wr_ptr_q] <= wr_data_i;
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_o  <= '0;
      end else begin
         if (wr_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (rd_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({wr_ok, rd_ok})
            2'b10:   count_o <= count_o + CW'(1);
            2'b01:   count_o <= count_o - CW'(1);
            default: count_o <= count_o;
         endcase
      end
   end

   assign rd_data_o = empty_o ? '0 : mem[rd_ptr_q];

endmodule

// File: rtl/sobel_control.sv
// Streaming 1-D edge magnitude |p[n] - p[n-2]| over the pixels since start.
// The first two pixels after start_sobel_i only fill the window and produce
// no output, so a frame of N pixels yields N-2 results.
//   clk_i, rst_ni        : clock, async active-low reset
//   start_sobel_i        : clear window at frame start
//   px_rdy_i / pixel_i   : input strobe and 8-bit pixel
//   px_rdy_o / sobel_o   : output strobe and magnitude, one cycle later
module sobel_control
   import gray_sobel_pkg::*;
(
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       start_sobel_i,
   input  logic                       px_rdy_i,
   input  logic [PIXEL_WIDTH_OUT-1:0] pixel_i,
   output logic                       px_rdy_o,
   output logic [PIXEL_WIDTH_OUT-1:0] sobel_o
);
   logic [PIXEL_WIDTH_OUT-1:0] w1_q, w2_q;
   logic [1:0]                 fill_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         w1_q     <= '0;
         w2_q     <= '0;
         fill_q   <= '0;
         px_rdy_o <= 1'b0;
         sobel_o  <= '0;
      end else begin
         px_rdy_o <= 1'b0;
         if (start_sobel_i) begin
            w1_q   <= '0;
            w2_q   <= '0;
            fill_q <= '0;
         end else if (px_rdy_i) begin
            if (fill_q == 2'd2) begin
               px_rdy_o <= 1'b1;
               sobel_o  <= (pixel_i >= w2_q) ? pixel_i - w2_q : w2_q - pixel_i;
            end else begin
               fill_q <= fill_q + 2'd1;
            end
            w2_q <= w1_q;
            w1_q <= pixel_i;
         end
      end
   end

endmodule

// File: rtl/gray_sobel_stream_top.sv
// Frame-based streaming wrapper: valid/ready input, per-frame mode latch,
// credit-based input throttling, optional sobel binarisation, output FIFO.
//   clk_i, reset_i              : clock, async active-high reset
//   start_i, mode_i             : frame start (IDLE only) and mode to latch
//   thresh_en_i, thresh_i       : sobel binarisation control, latched at start
//   in_valid_i/in_ready_o/in_pixel_i    : input stream
//   out_valid_o/out_ready_i/out_pixel_o : FIFO head stream
//   busy_o, frame_done_o        : not IDLE / DRAIN->IDLE pulse
//   overflow_o, timeout_o       : sticky per-frame error flags
//   px_count_o                  : pixels accepted this frame
module gray_sobel_stream_top #(
   parameter  int PIXEL_WIDTH_IN  = 24,
   parameter  int PIXEL_WIDTH_OUT = 8,
   parameter  int FRAME_PIXELS    = 4096,
   parameter  int FIFO_DEPTH      = 8,
   parameter  int PIPE_LAT_MAX    = 4,
   parameter  int DRAIN_TIMEOUT   = 1024,
   localparam int CNT_W           = $clog2(FRAME_PIXELS + 1)
) (
   input  logic                      clk_i,
   input  logic                      reset_i,
   input  logic                      start_i,
   input  logic [1:0]                mode_i,
   input  logic                      thresh_en_i,
   input  logic [7:0]                thresh_i,
   input  logic                      in_valid_i,
   output logic                      in_ready_o,
   input  logic [PIXEL_WIDTH_IN-1:0] in_pixel_i,
   output logic                      out_valid_o,
   input  logic                      out_ready_i,
   output logic [PIXEL_WIDTH_IN-1:0] out_pixel_o,
   output logic                      busy_o,
   output logic                      frame_done_o,
   output logic                      overflow_o,
   output logic                      timeout_o,
   output logic [CNT_W-1:0]          px_count_o
);
   import gray_sobel_pkg::*;

   localparam int PAD  = PIXEL_WIDTH_IN - PIXEL_WIDTH_OUT;
   localparam int FC_W = $clog2(FIFO_DEPTH + 1);
   localparam int DR_W = $clog2(DRAIN_TIMEOUT + 1);

   state_e                     state_q, state_d;
   mode_e                      mode_q, mode_live;
   logic                       thr_en_q;
   logic [7:0]                 thr_q;
   logic [CNT_W-1:0]           px_count_q;
   logic [FC_W-1:0]            inflight_q;
   logic [DR_W-1:0]            drain_cnt_q;
   logic                       byp_vld_q;
   logic [PIXEL_WIDTH_IN-1:0]  byp_data_q;

   logic                       accept, frame_start, last_px;
   logic                       drain_empty, drain_to;
   logic [31:0]                credit_used;
   logic                       gray_go, gray_rdy, sobel_go, sobel_rdy, sobel_start;
   logic [PIXEL_WIDTH_OUT-1:0] gray_px, sobel_in, sobel_px, sobel_thr;
   logic                       fifo_wr, fifo_empty, fifo_drop;
   logic [PIXEL_WIDTH_IN-1:0]  fifo_din;
   logic [FC_W-1:0]            fifo_cnt;

   assign mode_live   = mode_e'(mode_i);
   assign frame_start = (state_q == IDLE) && start_i;
   assign busy_o      = (state_q != IDLE);
   assign px_count_o  = px_count_q;
   assign out_valid_o = !fifo_empty;

   // Credit: keep PIPE_LAT_MAX free slots so every pixel already in the
   // cores has a landing place. Built from registers only.
   assign credit_used = 32'(fifo_cnt) + 32'(inflight_q);
   assign in_ready_o  = (state_q == RUN) &&
                        (credit_used + 32'(PIPE_LAT_MAX) < 32'(FIFO_DEPTH));
   assign accept      = in_valid_i && in_ready_o;
   assign last_px     = (px_count_q == CNT_W'(FRAME_PIXELS - 1));
   assign drain_empty = (inflight_q == '0) && fifo_empty;

   // ---------------- FSM ----------------
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d      = state_q;
      frame_done_o = 1'b0;
      drain_to     = 1'b0;
      case (state_q)
         IDLE:  if (start_i) state_d = RUN;
         RUN:   if (accept && last_px) state_d = DRAIN;
         DRAIN: begin
            if (drain_empty || drain_cnt_q == DR_W'(DRAIN_TIMEOUT - 1)) begin
               state_d      = IDLE;
               frame_done_o = 1'b1;
               drain_to     = !drain_empty;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // ---------------- frame bookkeeping ----------------
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         mode_q      <= MODE_FULL;
         thr_en_q    <= 1'b0;
         thr_q       <= '0;
         px_count_q  <= '0;
         inflight_q  <= '0;
         drain_cnt_q <= '0;
         overflow_o  <= 1'b0;
         timeout_o   <= 1'b0;
         byp_vld_q   <= 1'b0;
         byp_data_q  <= '0;
      end else begin
         byp_vld_q  <= accept && (mode_q == MODE_BYPASS);
         byp_data_q <= in_pixel_i;
         if (frame_start) begin
            mode_q     <= mode_live;
            thr_en_q   <= thresh_en_i;
            thr_q      <= thresh_i;
            px_count_q <= '0;
            overflow_o <= 1'b0;
            timeout_o  <= 1'b0;
            // a timed-out frame can leave phantom in-flight credit behind
            inflight_q <= '0;
         end else begin
            if (accept) px_count_q <= px_count_q + CNT_W'(1);
            case ({accept, fifo_wr})
               2'b10:   inflight_q <= inflight_q + FC_W'(1);
               2'b01:   if (inflight_q != '0) inflight_q <= inflight_q - FC_W'(1);
               default: inflight_q <= inflight_q;
            endcase
         end
         drain_cnt_q <= (state_q == DRAIN) ? drain_cnt_q + DR_W'(1) : '0;
         if (fifo_drop) overflow_o <= 1'b1;
         if (drain_to)  timeout_o  <= 1'b1;
      end
   end

   // ---------------- core routing ----------------
   assign gray_go     = accept && (mode_q == MODE_FULL || mode_q == MODE_GRAY);
   assign sobel_go    = (mode_q == MODE_FULL) ? gray_rdy : (accept && mode_q == MODE_SOBEL);
   assign sobel_in    = (mode_q == MODE_FULL) ? gray_px : in_pixel_i[PIXEL_WIDTH_OUT-1:0];
   // mode comes straight from the port: the shadow copy updates on this same edge
   assign sobel_start = frame_start && (mode_live == MODE_FULL || mode_live == MODE_SOBEL);

   gray_scale_core u_gray (
      .clk_i    (clk_i),
      .rst_ni   (~reset_i),
      .px_rdy_i (gray_go),
      .pixel_i  (in_pixel_i),
      .px_rdy_o (gray_rdy),
      .gray_o   (gray_px)
   );

   sobel_control u_sobel (
      .clk_i         (clk_i),
      .rst_ni        (~reset_i),
      .start_sobel_i (sobel_start),
      .px_rdy_i      (sobel_go),
      .pixel_i       (sobel_in),
      .px_rdy_o      (sobel_rdy),
      .sobel_o       (sobel_px)
   );

   assign sobel_thr = !thr_en_q ? sobel_px : ((sobel_px >= thr_q) ? 8'hFF : 8'h00);

   always_comb begin
      fifo_wr  = 1'b0;
      fifo_din = '0;
      case (mode_q)
         MODE_BYPASS: begin
            fifo_wr  = byp_vld_q;
            fifo_din = byp_data_q;
         end
         MODE_GRAY: begin
            fifo_wr  = gray_rdy;
            fifo_din = {{PAD{1'b0}}, gray_px};
         end
         default: begin
            fifo_wr  = sobel_rdy;
            fifo_din = {{PAD{1'b0}}, sobel_thr};
         end
      endcase
   end

   px_out_fifo #(
      .WIDTH (PIXEL_WIDTH_IN),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .wr_en_i   (fifo_wr),
      .wr_data_i (fifo_din),
      .rd_en_i   (out_ready_i),
      .rd_data_o (out_pixel_o),
      .empty_o   (fifo_empty),
      .count_o   (fifo_cnt),
      .drop_o    (fifo_drop)
   );

endmodule
